// File: rtl/fir_output_checker_pkg.sv
// ---------------------------------------------------------------------------
// fir_output_checker_pkg
// Shared definitions for the FIR output checker: run-state encoding and the
// default widths/depths used by the checker top and its skew FIFOs.
// No ports (package).
// ---------------------------------------------------------------------------
package fir_output_checker_pkg;

  localparam int DW_DEF       = 22;   // filter output sample width
  localparam int AW_DEF       = 8;    // sample index width
  localparam int NSAMP_DEF    = 256;  // samples compared per run
  localparam int SKEW_MAX_DEF = 8;    // alignment FIFO depth

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

endpackage

// File: rtl/fir_output_checker_skew_fifo.sv
// ---------------------------------------------------------------------------
// fir_output_checker_skew_fifo
// Small synchronous FIFO that absorbs the latency skew between the two FIR
// output streams. Pointers carry one extra wrap bit so full/empty are exact.
// A push while full is accepted only when a pop happens on the same edge.
//
// Ports:
//   clk    in   clock, rising edge
//   rstn   in   asynchronous active-low reset (FIFO empty)
//   clr    in   synchronous flush, wins over push/pop
//   push   in   write wdata this cycle
//   wdata  in   DW-bit sample
//   pop    in   drop the head entry this cycle
//   rdata  out  current head entry (valid when !empty)
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
// ---------------------------------------------------------------------------
module fir_output_checker_skew_fifo
  import fir_output_checker_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = SKEW_MAX_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW:0]   wptr_q;
  logic [PW:0]   rptr_q;
  logic          doPush;
  logic          doPop;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign doPop  = pop && !empty;
  // A full FIFO can still take a write when the head leaves on the same edge.
  assign doPush = push && (!full || doPop);
  assign rdata  = mem_q[rptr_q[PW-1:0]];

  // Pointer bookkeeping; a flush simply re-aligns both pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (doPush) wptr_q <= wptr_q + PTR_ONE;
      if (doPop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say so.
  always_ff @(posedge clk) begin
    if (doPush && !clr) mem_q[wptr_q[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fir_output_checker.sv
// ---------------------------------------------------------------------------
// fir_output_checker
// Compares the direct-form and transposed-form FIR output streams sample by
// sample. Each stream is buffered in its own skew FIFO; whenever both FIFOs
// hold a sample the two heads are popped and compared. The run ends after
// NSAMP compares or when a push finds its FIFO full (overflow).
//
// Optional feature macro: FIR_CHK_TOLERANCE_EN
//   defined   -> samples match when |d - t| <= 1 LSB
//   undefined -> samples must be exactly equal
//
// Ports:
//   clk            in   clock, rising edge
//   rstn           in   asynchronous active-low reset
//   start          in   one-cycle pulse, starts a run from IDLE or DONE
//   d_valid/d_data in   direct-form sample stream
//   t_valid/t_data in   transposed-form sample stream
//   busy           out  run in progress
//   done           out  run finished
//   pass           out  valid with done: no mismatches and no overflow
//   overflow       out  sticky: a sample was dropped on a full FIFO
//   mismatch_cnt   out  mismatching pairs this run (saturating)
//   sample_cnt     out  compared pairs this run
//   first_err_idx  out  sample_cnt at the first mismatch
//   first_err_vld  out  first_err_idx holds a capture
// ---------------------------------------------------------------------------
module fir_output_checker
  import fir_output_checker_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int NSAMP    = NSAMP_DEF,
  parameter int SKEW_MAX = SKEW_MAX_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          d_valid,
  input  logic [DW-1:0] d_data,
  input  logic          t_valid,
  input  logic [DW-1:0] t_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          overflow,
  output logic [AW:0]   mismatch_cnt,
  output logic [AW:0]   sample_cnt,
  output logic [AW-1:0] first_err_idx,
  output logic          first_err_vld
);

  localparam logic [AW:0] LAST_IDX = (AW + 1)'(NSAMP - 1);
  localparam logic [AW:0] CNT_MAX  = '1;
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  chk_state_e    state_q;
  logic          pass_q;
  logic          overflow_q;
  logic [AW:0]   mismatch_cnt_q;
  logic [AW:0]   sample_cnt_q;
  logic [AW-1:0] first_err_idx_q;
  logic          first_err_vld_q;

  logic          inRun;
  logic          runStart;
  logic          dFull, dEmpty, tFull, tEmpty;
  logic [DW-1:0] dHead, tHead;
  logic          pairPop;
  logic          dPush, tPush;
  logic          ovfEvent;
  logic          lastPair;
  logic          match;
  logic [AW:0]   mismatch_cnt_d;

  assign inRun    = (state_q == RUN);
  assign runStart = start && !inRun;
  assign pairPop  = inRun && !dEmpty && !tEmpty;

  // A push may only land in a full FIFO when that FIFO's head leaves on the
  // same edge; otherwise the sample is lost and the run is aborted.
  assign dPush    = inRun && d_valid && (!dFull || pairPop);
  assign tPush    = inRun && t_valid && (!tFull || pairPop);
  assign ovfEvent = inRun && ((d_valid && dFull && !pairPop) ||
                              (t_valid && tFull && !pairPop));
  assign lastPair = pairPop && (sample_cnt_q == LAST_IDX);

`ifdef FIR_CHK_TOLERANCE_EN
  // One extra bit keeps the signed difference from wrapping.
  logic signed [DW:0] diff;
  assign diff  = $signed({dHead[DW-1], dHead}) - $signed({tHead[DW-1], tHead});
  assign match = (diff == '0) || (diff == '1) || (diff == (DW + 1)'(1));
`else
  assign match = (dHead == tHead);
`endif

  // Mismatch counter sticks at its maximum instead of wrapping to zero.
  always_comb begin
    mismatch_cnt_d = mismatch_cnt_q;
    if (pairPop && !match && (mismatch_cnt_q != CNT_MAX))
      mismatch_cnt_d = mismatch_cnt_q + CNT_ONE;
  end

  fir_output_checker_skew_fifo #(.DW(DW), .DEPTH(SKEW_MAX)) uDFifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (runStart),
    .push  (dPush),
    .wdata (d_data),
    .pop   (pairPop),
    .rdata (dHead),
    .full  (dFull),
    .empty (dEmpty)
  );

  fir_output_checker_skew_fifo #(.DW(DW), .DEPTH(SKEW_MAX)) uTFifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (runStart),
    .push  (tPush),
    .wdata (t_data),
    .pop   (pairPop),
    .rdata (tHead),
    .full  (tFull),
    .empty (tEmpty)
  );

  // Run-control FSM plus all result registers. pass is resolved on the edge
  // that ends the run, using the mismatch count that edge produces.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      pass_q          <= 1'b0;
      overflow_q      <= 1'b0;
      mismatch_cnt_q  <= '0;
      sample_cnt_q    <= '0;
      first_err_idx_q <= '0;
      first_err_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q         <= RUN;
            pass_q          <= 1'b0;
            overflow_q      <= 1'b0;
            mismatch_cnt_q  <= '0;
            sample_cnt_q    <= '0;
            first_err_idx_q <= '0;
            first_err_vld_q <= 1'b0;
          end
        end
        RUN: begin
          mismatch_cnt_q <= mismatch_cnt_d;
          if (pairPop) begin
            sample_cnt_q <= sample_cnt_q + CNT_ONE;
            if (!match && !first_err_vld_q) begin
              first_err_idx_q <= sample_cnt_q[AW-1:0];
              first_err_vld_q <= 1'b1;
            end
          end
          if (ovfEvent) overflow_q <= 1'b1;
          if (ovfEvent || lastPair) begin
            state_q <= DONE;
            pass_q  <= (mismatch_cnt_d == '0) && !ovfEvent;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign pass          = pass_q;
  assign overflow      = overflow_q;
  assign mismatch_cnt  = mismatch_cnt_q;
  assign sample_cnt    = sample_cnt_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_vld = first_err_vld_q;

endmodule

// File: tb/tb_fir_output_checker.sv
// ---------------------------------------------------------------------------
// tb_fir_output_checker
// Directed bench for fir_output_checker with default parameters
// (DW=22, AW=8, NSAMP=256, SKEW_MAX=8). Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_fir_output_checker;

  localparam int DW = 22;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          d_valid;
  logic [DW-1:0] d_data;
  logic          t_valid;
  logic [DW-1:0] t_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic          overflow;
  logic [AW:0]   mismatch_cnt;
  logic [AW:0]   sample_cnt;
  logic [AW-1:0] first_err_idx;
  logic          first_err_vld;

  int compareCount  = 0;
  int mismatchCount = 0;
  int doneAt;

  always #5 clk = ~clk;

  fir_output_checker dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .d_valid       (d_valid),
    .d_data        (d_data),
    .t_valid       (t_valid),
    .t_data        (t_data),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .overflow      (overflow),
    .mismatch_cnt  (mismatch_cnt),
    .sample_cnt    (sample_cnt),
    .first_err_idx (first_err_idx),
    .first_err_vld (first_err_vld)
  );

  // One comparison: counts it, and on disagreement counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Pulses start, then streams d samples 0..dCount-1 and t samples delayed by
  // tDelay cycles with value idx+allAdd (+errAdd at errIdx). Drives and
  // samples on the falling edge. Loop index c is observed after rising edge c.
  // Returns the loop index where done was first seen, or -1.
  task automatic applyStimulus(input int dCount, input int tCount,
                               input int tDelay, input int errIdx,
                               input int errAdd, input int allAdd,
                               input int abortAt, output int seenDone);
    int idx;
    seenDone = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 0) checkOutput("busyAfterStart", 32'(busy), 32'd1);
      if (abortAt >= 0 && c == abortAt) break;
      if (done) begin
        seenDone = c;
        break;
      end
      d_valid = (c < dCount);
      d_data  = DW'(c);
      idx     = c - tDelay;
      t_valid = (idx >= 0) && (idx < tCount);
      t_data  = DW'(idx + allAdd + ((idx == errIdx) ? errAdd : 0));
    end
    d_valid = 1'b0;
    t_valid = 1'b0;
  endtask

  initial begin
    rstn    = 1'b0;
    start   = 1'b0;
    d_valid = 1'b0;
    d_data  = '0;
    t_valid = 1'b0;
    t_data  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rstBusy",     32'(busy),          32'd0);
    checkOutput("rstDone",     32'(done),          32'd0);
    checkOutput("rstPass",     32'(pass),          32'd0);
    checkOutput("rstOverflow", 32'(overflow),      32'd0);
    checkOutput("rstMisCnt",   32'(mismatch_cnt),  32'd0);
    checkOutput("rstSmpCnt",   32'(sample_cnt),    32'd0);
    checkOutput("rstErrVld",   32'(first_err_vld), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Identical ramps, same cycle
    applyStimulus(256, 256, 0, -1, 0, 0, -1, doneAt);
    checkOutput("rampDoneCycle", 32'(doneAt),       32'd257);
    checkOutput("rampPass",      32'(pass),         32'd1);
    checkOutput("rampMisCnt",    32'(mismatch_cnt), 32'd0);
    checkOutput("rampSmpCnt",    32'(sample_cnt),   32'd256);
    checkOutput("rampBusy",      32'(busy),         32'd0);

    // t delayed by 5 cycles
    applyStimulus(256, 256, 5, -1, 0, 0, -1, doneAt);
    checkOutput("skewDoneCycle", 32'(doneAt),     32'd262);
    checkOutput("skewPass",      32'(pass),       32'd1);
    checkOutput("skewOverflow",  32'(overflow),   32'd0);
    checkOutput("skewSmpCnt",    32'(sample_cnt), 32'd256);

    // Sample 17 of t off by +3
    applyStimulus(256, 256, 0, 17, 3, 0, -1, doneAt);
    checkOutput("err17Done",   32'(done),          32'd1);
    checkOutput("err17MisCnt", 32'(mismatch_cnt),  32'd1);
    checkOutput("err17Idx",    32'(first_err_idx), 32'd17);
    checkOutput("err17Vld",    32'(first_err_vld), 32'd1);
    checkOutput("err17Pass",   32'(pass),          32'd0);

    // t silent, d sends 9 samples into a depth-8 FIFO
    applyStimulus(9, 0, 0, -1, 0, 0, -1, doneAt);
    checkOutput("ovfDoneCycle", 32'(doneAt),     32'd9);
    checkOutput("ovfOverflow",  32'(overflow),   32'd1);
    checkOutput("ovfDone",      32'(done),       32'd1);
    checkOutput("ovfPass",      32'(pass),       32'd0);
    checkOutput("ovfSmpCnt",    32'(sample_cnt), 32'd0);

    // t = d + 1 everywhere; also relies on the stale D-FIFO being flushed
    applyStimulus(256, 256, 0, -1, 0, 1, -1, doneAt);
    checkOutput("offByOneDone",   32'(done),       32'd1);
    checkOutput("offByOneSmpCnt", 32'(sample_cnt), 32'd256);
`ifdef FIR_CHK_TOLERANCE_EN
    checkOutput("offByOneMisCnt", 32'(mismatch_cnt),  32'd0);
    checkOutput("offByOnePass",   32'(pass),          32'd1);
    checkOutput("offByOneVld",    32'(first_err_vld), 32'd0);
`else
    checkOutput("offByOneMisCnt", 32'(mismatch_cnt),  32'd256);
    checkOutput("offByOneIdx",    32'(first_err_idx), 32'd0);
    checkOutput("offByOneVld",    32'(first_err_vld), 32'd1);
    checkOutput("offByOnePass",   32'(pass),          32'd0);
`endif

    // Reset in the middle of a run, then a clean rerun
    applyStimulus(256, 256, 0, 20, 5, 0, 100, doneAt);
    checkOutput("midRunSmpCnt", 32'(sample_cnt),    32'd99);
    checkOutput("midRunErrVld", 32'(first_err_vld), 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("midRstBusy",   32'(busy),          32'd0);
    checkOutput("midRstDone",   32'(done),          32'd0);
    checkOutput("midRstSmpCnt", 32'(sample_cnt),    32'd0);
    checkOutput("midRstMisCnt", 32'(mismatch_cnt),  32'd0);
    checkOutput("midRstErrIdx", 32'(first_err_idx), 32'd0);
    checkOutput("midRstErrVld", 32'(first_err_vld), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(256, 256, 0, -1, 0, 0, -1, doneAt);
    checkOutput("rerunDoneCycle", 32'(doneAt),     32'd257);
    checkOutput("rerunPass",      32'(pass),       32'd1);
    checkOutput("rerunSmpCnt",    32'(sample_cnt), 32'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/fir_output_checker.md
# fir_output_checker

Downstream stage of the FIR filter pair: consumes the 22-bit direct-form and transposed-form output streams as they are written to the output memories, aligns them through small skew FIFOs, and compares them sample by sample. It counts compared samples and mismatches, latches the index of the first mismatch, and raises done/pass after a programmed number of samples, giving a self-check without memory readback.

## Interface
- DW, 22, sample width of both filter outputs
- AW, 8, sample index width; one run compares NSAMP samples
- NSAMP, 256, samples compared per run (1..2^AW)
- SKEW_MAX, 8, depth of each alignment FIFO (power of 2, ≥2)

- clk  in  1  single clock, rising-edge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- d_valid  in  1  direct-form sample present this cycle
- d_data  in  DW  direct-form sample, signed
- t_valid  in  1  transposed-form sample present this cycle
- t_data  in  DW  transposed-form sample, signed
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  valid when done; 1 = zero mismatches and no overflow
- overflow  out  1  sticky; a push hit a full FIFO
- mismatch_cnt  out  AW+1  mismatches this run, saturating at 2^(AW+1)-1
- sample_cnt  out  AW+1  compared pairs this run
- first_err_idx  out  AW  sample_cnt value at first mismatch
- first_err_vld  out  1  first_err_idx holds a valid capture

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start → RUN; counters, flags, first_err_* and both FIFOs cleared on that edge.
- RUN: d_valid pushes d_data into D-FIFO; t_valid pushes t_data into T-FIFO. When both FIFOs non-empty, both heads are popped and compared at that edge.
- Compare: exact equality of DW-bit values. Mismatch → mismatch_cnt+1 (saturating); first mismatch of the run captures first_err_idx = current sample_cnt and sets first_err_vld.
- sample_cnt increments per compared pair; the compare that makes sample_cnt reach NSAMP moves state to DONE on the same edge.
- Push to a full FIFO without a simultaneous pop from that FIFO: sample dropped, overflow set, state → DONE. Push and pop on a full FIFO in the same cycle is legal.
- DONE: pass = (mismatch_cnt==0) && !overflow. All outputs hold. start → RUN with full clear as from IDLE.
- start in RUN ignored. d_valid/t_valid outside RUN ignored. Samples left in FIFOs at DONE are discarded by the next start.

## Timing
- Reset values: busy 0, done 0, pass 0, overflow 0, mismatch_cnt 0, sample_cnt 0, first_err_idx 0, first_err_vld 0; FIFOs empty.
- Push at edge k makes the sample a FIFO head after edge k; earliest compare at edge k+1, counters visible after k+1.
- Equal-latency streams: 1 pair compared per cycle, steady state; skew up to SKEW_MAX cycles absorbed without loss.
- done rises the cycle after the edge completing the NSAMP-th compare or detecting overflow.
- Reset mid-run: immediate return to reset values; run lost.

## Configuration
- FIR_CHK_TOLERANCE_EN: defined → compare passes when |d - t| ≤ 1 LSB (signed DW+1-bit difference, no wrap); undefined → exact equality only. No interface change.

## Structure
- Shared include fir_chk_defs.v: state encodings (IDLE/RUN/DONE), default DW/AW/SKEW_MAX constants.
- Sub-module fir_skew_fifo (synchronous FIFO, DW x SKEW_MAX, full/empty, async active-low reset), instantiated twice.

## Test plan
- Identical ramps 0..255 on both streams, same cycle, NSAMP=256 → done after 257th edge from start, pass=1, mismatch_cnt=0, sample_cnt=256.
- t stream delayed 5 cycles vs d, identical data → pass=1, no overflow.
- Sample 17 of t = d+3 → mismatch_cnt=1, first_err_idx=17, first_err_vld=1, pass=0.
- t stream silent, d streams 9 samples with SKEW_MAX=8 → overflow=1, done=1, pass=0, sample_cnt=0.
- t = d+1 on every sample → without FIR_CHK_TOLERANCE_EN mismatch_cnt=256, first_err_idx=0; with it pass=1.
- rstn low at sample 100 → all outputs return to reset values; new start re-runs cleanly to pass=1.
